// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional feature macro MDU_MADD_EN enables madd/maddu (HI/LO accumulate).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 4;
  localparam int unsigned XW = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {PK_MUL, PK_DIV, PK_DIVZ, PK_MADD} pend_t;

  state_t          state, state_d;
  pend_t           kind, kind_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d;
  logic [XW-1:0]   hi_d, lo_d;
  logic [2*XW-1:0] pend, pend_d;

  logic [2*XW-1:0] prod_s, prod_u, prod;
  logic            prod_signed;
  logic            div_signed, a_neg, b_neg;
  logic [XW-1:0]   dvd, dvs, q_u, r_u, q, r;

  // Product of the operands presented at the start edge.
  always_comb begin
    prod_s = $signed({{XW{a[XW-1]}}, a}) * $signed({{XW{b[XW-1]}}, b});
    prod_u = {XW'(0), a} * {XW'(0), b};
`ifdef MDU_MADD_EN
    prod_signed = (mdop == OP_MULT) || (mdop == OP_MADD);
`else
    prod_signed = (mdop == OP_MULT);
`endif
    prod = prod_signed ? prod_s : prod_u;
  end

  // Signed divide via magnitudes; avoids the -2^31 / -1 overflow case entirely.
  always_comb begin
    div_signed = (mdop == OP_DIV);
    a_neg      = div_signed & a[XW-1];
    b_neg      = div_signed & b[XW-1];
    dvd        = a_neg ? (~a + XW'(1)) : a;
    dvs        = b_neg ? (~b + XW'(1)) : b;
    q_u        = '0;
    r_u        = '0;
    if (dvs != '0) begin
      q_u = dvd / dvs;
      r_u = dvd % dvs;
    end
    q = (a_neg ^ b_neg) ? (~q_u + XW'(1)) : q_u;
    r = a_neg ? (~r_u + XW'(1)) : r_u;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      kind  <= PK_MUL;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      pend  <= '0;
    end else begin
      state <= state_d;
      kind  <= kind_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      hi    <= hi_d;
      lo    <= lo_d;
      pend  <= pend_d;
    end
  end

  always_comb begin
    state_d = state;
    kind_d  = kind;
    cnt_d   = cnt;
    busy_d  = busy;
    hi_d    = hi;
    lo_d    = lo;
    pend_d  = pend;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(MULT_CYCLES - 1);
              pend_d  = prod;
              kind_d  = PK_MUL;
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(DIV_CYCLES - 1);
              pend_d  = {r, q};
              kind_d  = (dvs == '0) ? PK_DIVZ : PK_DIV;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(MULT_CYCLES - 1);
              pend_d  = prod;
              kind_d  = PK_MADD;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored for the whole RUN state, commit cycle included.
        if (cnt == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          case (kind)
            PK_MUL, PK_DIV: {hi_d, lo_d} = pend;
`ifdef MDU_MADD_EN
            PK_MADD:        {hi_d, lo_d} = {hi, lo} + pend;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default 5/10 cycle latencies).
module tb_mult_div_unit;

  logic        clk, reset, start;
  logic [3:0]  mdop;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; operands are scrambled afterwards.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; mdop = op; a = x; b = y;
    tick();
    start = 1'b0; mdop = 4'd0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mdop = 4'd0; a = '0; b = '0;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      errors++; $display("FAIL reset_state got busy=%b hi=%h lo=%h want all 0", busy, hi, lo);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", n); end
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL mult_result got %h_%h want ffffffff_fffffffe", hi, lo);
    end
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", n); end
    vectors++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL multu_result got %h_%h want 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d want 10", n); end
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin errors++; $display("FAIL divz_cycles got %0d want 10", n); end
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL divz_unchanged got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    vectors++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo);
    end
    issue(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    vectors++;
    if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
      errors++; $display("FAIL divu_100_7 got %h_%h want 00000002_0000000e", hi, lo);
    end
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    vectors++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
      errors++; $display("FAIL div_7_m2 got %h_%h want 00000001_fffffffd", hi, lo);
    end
  endtask

  task automatic test_mtx();
    int n;
    issue(4'd5, 32'h1234_5678, 32'd0);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 64'h1234_5678_FFFF_FFFD}) begin
      errors++; $display("FAIL mthi got busy=%b hi=%h lo=%h want 0 12345678 fffffffd", busy, hi, lo);
    end
    issue(4'd6, 32'hAAAA_5555, 32'd0);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 64'h1234_5678_AAAA_5555}) begin
      errors++; $display("FAIL mtlo got busy=%b hi=%h lo=%h want 0 12345678 aaaa5555", busy, hi, lo);
    end
    issue(4'd1, 32'd2, 32'd3);
    issue(4'd6, 32'hDEAD_BEEF, 32'd0);
    vectors++;
    if ({busy, lo} !== {1'b1, 32'hAAAA_5555}) begin
      errors++; $display("FAIL mtlo_busy got busy=%b lo=%h want 1 aaaa5555", busy, lo);
    end
    wait_idle(n);
    vectors++;
    if ({hi, lo} !== 64'd6) begin
      errors++; $display("FAIL mult_after_mtlo got %h_%h want 00000000_00000006", hi, lo);
    end
  endtask

  task automatic test_reserved();
    logic [3:0] codes [$];
    codes = '{4'd0, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`ifndef MDU_MADD_EN
    codes.push_back(4'd7);
    codes.push_back(4'd8);
`endif
    foreach (codes[i]) begin
      issue(codes[i], 32'h1111_1111, 32'd2);
      tick();
      vectors++;
      if ({busy, hi, lo} !== {1'b0, 64'd6}) begin
        errors++;
        $display("FAIL reserved_%0d got busy=%b hi=%h lo=%h want 0 0 6", codes[i], busy, hi, lo);
      end
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int n;
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin errors++; $display("FAIL maddu_cycles got %0d want 5", n); end
    vectors++;
    if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL maddu got %h_%h want 00000001_00000000", hi, lo);
    end
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_idle(n);
    vectors++;
    if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin
      errors++; $display("FAIL madd got %h_%h want 00000000_ffffffff", hi, lo);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h want all 0", busy, hi, lo);
    end
    tick();
    reset = 1'b1;
    issue(4'd1, 32'd3, 32'd4);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin errors++; $display("FAIL post_reset_cycles got %0d want 5", n); end
    vectors++;
    if ({hi, lo} !== 64'd12) begin
      errors++; $display("FAIL post_reset_mult got %h_%h want 00000000_0000000c", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'd5, 32'd6);
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_commit_busy got %b want 1", busy); end
    start = 1'b1; mdop = 4'd4; a = 32'd20; b = 32'd3;
    tick();
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 64'd30}) begin
      errors++; $display("FAIL b2b_first_ignored got busy=%b hi=%h lo=%h want 0 0 1e", busy, hi, lo);
    end
    tick();
    start = 1'b0; mdop = 4'd0; a = $urandom; b = $urandom;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b want 1", busy); end
    wait_idle(n);
    vectors++;
    if (n !== 10) begin errors++; $display("FAIL b2b_div_cycles got %0d want 10", n); end
    vectors++;
    if ({hi, lo} !== 64'h0000_0002_0000_0006) begin
      errors++; $display("FAIL b2b_divu got %h_%h want 00000002_00000006", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtx();
    test_reserved();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have the parameter MULT_CYCLES, default 5, giving the number of busy cycles for a multiply.
REQ-002 The block SHALL have the parameter DIV_CYCLES, default 10, giving the number of busy cycles for a divide.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset (0 = reset).
REQ-005 The port start SHALL be an input, 1 bit wide, and qualify mdop in the current cycle.
REQ-006 The port mdop SHALL be an input, 4 bits wide, with encoding 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; 9-15 reserved.
REQ-007 The ports a and b SHALL be inputs, 32 bits wide each, carrying the forwarded rs and rt operands from the EX stage.
REQ-008 The port busy SHALL be an output, 1 bit wide, high while a multiply or divide is in flight.
REQ-009 The ports hi and lo SHALL be outputs, 32 bits wide each, carrying the architectural HI and LO registers directly from flops; they serve mfhi/mflo.

Function
REQ-010 The block SHALL have two states: IDLE and RUN, with a down-counter cnt of 4 bits.
REQ-011 In IDLE, start with mdop in 1-4 (or 7-8 with the macro) SHALL latch the operands, load cnt with MULT_CYCLES-1 or DIV_CYCLES-1, and go to RUN.
REQ-012 busy SHALL be high from the cycle after the start edge through the edge where HI/LO commit: exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-013 In RUN, cnt SHALL decrement each cycle; at cnt==0 the pending result SHALL be written to HI/LO, busy SHALL drop, and the state SHALL return to IDLE in the same edge.
REQ-014 mult SHALL produce a signed 64-bit product and multu an unsigned one; {HI,LO} SHALL receive the product.
REQ-015 div SHALL be signed and divu unsigned; LO SHALL receive the quotient and HI the remainder; the remainder sign SHALL follow the dividend; div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-016 A divide by zero SHALL still take DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-017 mthi and mtlo SHALL write a to HI or LO respectively on the start edge when in IDLE, with no busy.
REQ-018 start while busy (any mdop) SHALL be ignored; the upstream stall logic is responsible for holding it.
REQ-019 start in the commit cycle (busy high, cnt==0) SHALL be ignored; a new operation is accepted only when busy is low.
REQ-020 mdop 0 and the reserved codes SHALL have no effect.
REQ-021 Operands SHALL be sampled only at the start edge; later changes to a and b SHALL NOT affect the result.

Reset
REQ-022 reset low SHALL immediately force state IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the pending result, including mid-operation; no partial result is committed.
REQ-023 On reset release, the first edge SHALL be able to accept start.

Configuration
REQ-024 The macro MDU_MADD_EN SHALL, when defined, enable madd (signed) and maddu (unsigned): {HI,LO} <= {HI,LO} + a*b, mod 2^64, with MULT_CYCLES latency, using HI/LO as of the commit edge.
REQ-025 Without MDU_MADD_EN, codes 7 and 8 SHALL be treated as reserved (no effect, no busy).

Verification
REQ-026 Bench: mult a=0xFFFFFFFF, b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-027 Bench: div a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> hi and lo unchanged after 10 cycles.
REQ-028 Bench: mthi a=0x12345678 while idle -> hi=0x12345678 on the next edge, busy stays 0; mtlo issued while busy -> lo unchanged.
REQ-029 Bench: start div, then pull reset low at cycle 4 -> busy=0, hi=lo=0 immediately; release reset and start mult 3*4 -> lo=12 after 5 cycles.
REQ-030 Bench: with MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, then maddu a=1, b=1 -> hi=1, lo=0; without the macro, mdop=7 -> busy never rises, HI/LO unchanged.
REQ-031 Bench: back-to-back start on the commit edge and the edge after -> the first is ignored, the second is accepted, and busy rises the following cycle.
